redun_mont_sq_iter: RTL and testbench
=====================================

REDUN_MONT_SQ_ITER -- requirements
Module: redun_mont_sq_iter

Interface
REQ-001 SHALL have parameter WRD_BITS, default 16, word width in bits.
REQ-002 SHALL have parameter NUM_WRDS, default 64, operand width in words (DAT_BITS = WRD_BITS*NUM_WRDS).
REQ-003 SHALL have parameter ITER_W, default 32, width of the iteration count.
REQ-004 SHALL have i_clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have i_modulus  input  DAT_BITS  odd modulus P, sampled on accept.
REQ-007 SHALL have i_mont_inv  input  WRD_BITS  -P^-1 mod 2^WRD_BITS, sampled on accept.
REQ-008 SHALL have i_x  input  DAT_BITS  start value in Montgomery form, x < P.
REQ-009 SHALL have i_iter  input  ITER_W  number of squarings T.
REQ-010 SHALL have i_val / o_rdy  input / output  1 / 1  job request handshake.
REQ-011 SHALL have o_y  output  DAT_BITS  result, Montgomery form.
REQ-012 SHALL have o_val / i_rdy  output / input  1 / 1  result handshake.
REQ-013 SHALL have o_busy  output  1  job in progress.

Function
REQ-014 SHALL compute y = MontMul applied T times (y <- y*y*R^-1 mod P, R = 2^DAT_BITS), yielding y < P.
REQ-015 SHALL accept a job on a cycle with i_val && o_rdy; o_rdy high only in IDLE.
REQ-016 SHALL use FSM IDLE -> LOAD -> MULT -> RED -> SUB -> (MULT or DONE) -> IDLE.
REQ-017 SHALL use word-serial CIOS: per outer word i, MULT runs NUM_WRDS cycles (t += y_i*y_j), RED runs 1 cycle for m = t0*mont_inv and NUM_WRDS cycles for t += m*P then shift by one word.
REQ-018 SHALL run SUB for NUM_WRDS+1 cycles, with a word-serial borrow chain, choosing t-P if t >= P, else t.
REQ-019 SHALL use per-squaring latency L_SQ = NUM_WRDS*(2*NUM_WRDS+1) + NUM_WRDS + 1 cycles.
REQ-020 SHALL assert o_val exactly 2 + T*L_SQ cycles after the accept edge.
REQ-021 SHALL with T = 0 skip MULT and present o_y = i_x after 2 cycles.
REQ-022 SHALL hold o_val and o_y stable in DONE until i_rdy; return to IDLE on the o_val && i_rdy cycle.
REQ-023 SHALL ignore i_val while o_busy is high; o_busy high from LOAD through DONE.
REQ-024 SHALL keep the accumulator NUM_WRDS+2 words wide, so the carry never overflows for x < P.

Reset
REQ-025 SHALL on i_rst go to IDLE, with o_val=0, o_busy=0, o_rdy=1, o_y=0 and the iteration counter=0.
REQ-026 SHALL, when reset is asserted mid-job, discard the job; no o_val follows.

Configuration
REQ-027 SHALL, when REDUN_MONT_SQ_ABORT_EN is defined, add port i_abort (input, 1 bit).
REQ-028 SHALL, with REDUN_MONT_SQ_ABORT_EN, on i_abort in any busy state return to IDLE next cycle with no o_val.
REQ-029 SHALL, with REDUN_MONT_SQ_ABORT_EN, ignore i_abort in IDLE.
REQ-030 SHALL, without REDUN_MONT_SQ_ABORT_EN, have no i_abort port, and a job always completes.

Structure
REQ-031 SHALL place the state enum, the L_SQ function and the word/operand typedefs in package redun_mont_sq_pkg.
REQ-032 SHALL instantiate one sub-module mont_word_mac: (a, b, c_in, t_in) -> {carry, sum}, WRD_BITS x WRD_BITS + 2*WRD_BITS, combinational.

Verification (WRD_BITS=8, NUM_WRDS=2, P=0xFFF1, i_mont_inv=0xEF, L_SQ=13)
REQ-033 SHALL cover: x=0x000F, T=5 -> o_y=0x000F at 67 cycles after accept.
REQ-034 SHALL cover: x=0x001E, T=3 -> o_y=0x0F00 at 41 cycles after accept.
REQ-035 SHALL cover: x=0x1234, T=0 -> o_y=0x1234 at 2 cycles; x=0x0000, T=4 -> o_y=0x0000.
REQ-036 SHALL cover: x=0x001E, T=1 with i_rdy low 10 cycles -> o_y=0x003C held stable, and a second i_val during the job is ignored.
REQ-037 SHALL cover: reset at cycle 20 of the x=0x001E, T=3 job -> IDLE, o_rdy=1 next cycle, no o_val; then a new job runs correctly.
REQ-038 SHALL cover, with REDUN_MONT_SQ_ABORT_EN: i_abort at cycle 15 -> IDLE next cycle, no o_val; then an immediate job runs correctly.

Source files
------------

// File: rtl/redun_mont_sq_pkg.sv
// Shared types for the iterated Montgomery squarer: FSM states, default word/operand types
// and the per-squaring cycle count used by anything that needs to predict completion time.
package redun_mont_sq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MULT,
        ST_RED,
        ST_SUB,
        ST_DONE
    } state_t;

    localparam int DEF_WRD_BITS = 16;
    localparam int DEF_NUM_WRDS = 64;

    typedef logic [DEF_WRD_BITS-1:0]              word_t;
    typedef logic [DEF_WRD_BITS*DEF_NUM_WRDS-1:0] operand_t;

    // MULT + m + RED per outer word, then the final conditional subtract
    function automatic int l_sq(input int num_wrds);
        return num_wrds * (2 * num_wrds + 1) + num_wrds + 1;
    endfunction

endpackage

// File: rtl/redun_mont_sq_iter_mac.sv
// Word multiply-accumulate a*b + c_in + t_in; combinational, no backpressure.
// The result always fits in two words, returned as {carry, sum}.
module mont_word_mac #(
    parameter int WRD_BITS = 16
) (
    input  logic [WRD_BITS-1:0] a,
    input  logic [WRD_BITS-1:0] b,
    input  logic [WRD_BITS-1:0] c_in,
    input  logic [WRD_BITS-1:0] t_in,
    output logic [WRD_BITS-1:0] carry,
    output logic [WRD_BITS-1:0] sum
);

    logic [2*WRD_BITS-1:0] res;

    always_comb begin
        res = (2*WRD_BITS)'(a) * (2*WRD_BITS)'(b) + (2*WRD_BITS)'(c_in) + (2*WRD_BITS)'(t_in);
        carry = res[2*WRD_BITS-1:WRD_BITS];
        sum   = res[WRD_BITS-1:0];
    end

endmodule

// File: rtl/redun_mont_sq_iter.sv
// Word-serial CIOS Montgomery squarer applied i_iter times; o_val 2 + T*l_sq(NUM_WRDS) cycles after accept,
// result held until i_rdy. Optional abort port enabled by REDUN_MONT_SQ_ABORT_EN.
module redun_mont_sq_iter
    import redun_mont_sq_pkg::*;
#(
    parameter int WRD_BITS = 16,
    parameter int NUM_WRDS = 64,
    parameter int ITER_W   = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
`ifdef REDUN_MONT_SQ_ABORT_EN
    input  logic                         i_abort,
`endif
    input  logic [WRD_BITS*NUM_WRDS-1:0] i_modulus,
    input  logic [WRD_BITS-1:0]          i_mont_inv,
    input  logic [WRD_BITS*NUM_WRDS-1:0] i_x,
    input  logic [ITER_W-1:0]            i_iter,
    input  logic                         i_val,
    output logic                         o_rdy,
    output logic [WRD_BITS*NUM_WRDS-1:0] o_y,
    output logic                         o_val,
    input  logic                         i_rdy,
    output logic                         o_busy
);

    localparam int DAT_BITS = WRD_BITS * NUM_WRDS;
    localparam int ACC_BITS = WRD_BITS * (NUM_WRDS + 2);
    localparam int IDX_W    = $clog2(NUM_WRDS + 1);

    state_t                state_q, state_d;
    logic [DAT_BITS-1:0]   mod_q, y_q, d_q, d_d, y_d;
    logic [ACC_BITS-1:0]   t_q, t_d;
    logic [WRD_BITS-1:0]   inv_q, m_q, c_q;
    logic [IDX_W-1:0]      j_q, i_q;
    logic [ITER_W-1:0]     iter_q;
    logic                  borrow_q, borrow_d;
    logic                  abort_req;
    logic [WRD_BITS-1:0]   mac_a, mac_b, mac_c, mac_t, mac_hi, mac_lo;
    logic [WRD_BITS:0]     wide, diff;
    logic                  ge;
    int                    k;

`ifdef REDUN_MONT_SQ_ABORT_EN
    assign abort_req = i_abort;
`else
    assign abort_req = 1'b0;
`endif

    function automatic logic [WRD_BITS-1:0] wsel(input logic [ACC_BITS-1:0] v, input int idx);
        return WRD_BITS'(v >> (idx * WRD_BITS));
    endfunction

    function automatic logic [ACC_BITS-1:0] put_acc(input logic [ACC_BITS-1:0] v, input int idx,
                                                    input logic [WRD_BITS-1:0] w);
        logic [ACC_BITS-1:0] r;
        r = v;
        for (int n = 0; n < NUM_WRDS + 2; n++)
            if (n == idx) r[n*WRD_BITS +: WRD_BITS] = w;
        return r;
    endfunction

    function automatic logic [DAT_BITS-1:0] put_dat(input logic [DAT_BITS-1:0] v, input int idx,
                                                    input logic [WRD_BITS-1:0] w);
        logic [DAT_BITS-1:0] r;
        r = v;
        for (int n = 0; n < NUM_WRDS; n++)
            if (n == idx) r[n*WRD_BITS +: WRD_BITS] = w;
        return r;
    endfunction

    mont_word_mac #(.WRD_BITS(WRD_BITS)) u_mac (
        .a     (mac_a),
        .b     (mac_b),
        .c_in  (mac_c),
        .t_in  (mac_t),
        .carry (mac_hi),
        .sum   (mac_lo)
    );

    always_comb begin
        state_d = state_q;
        o_rdy   = 1'b0;
        o_val   = 1'b0;
        o_busy  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                o_rdy  = 1'b1;
                o_busy = 1'b0;
                if (i_val) state_d = ST_LOAD;
            end
            ST_LOAD: state_d = (iter_q == '0) ? ST_DONE : ST_MULT;
            ST_MULT: if (int'(j_q) == NUM_WRDS - 1) state_d = ST_RED;
            ST_RED:  if (int'(j_q) == NUM_WRDS)
                         state_d = (int'(i_q) == NUM_WRDS - 1) ? ST_SUB : ST_MULT;
            ST_SUB:  if (int'(j_q) == NUM_WRDS)
                         state_d = (iter_q == ITER_W'(1)) ? ST_DONE : ST_MULT;
            ST_DONE: begin
                o_val = 1'b1;
                if (i_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_req && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    always_comb begin
        mac_a    = '0;
        mac_b    = '0;
        mac_c    = '0;
        mac_t    = '0;
        t_d      = t_q;
        d_d      = d_q;
        y_d      = y_q;
        borrow_d = borrow_q;
        wide     = '0;
        diff     = '0;
        ge       = 1'b0;
        k        = 0;
        case (state_q)
            ST_MULT: begin
                k     = int'(j_q);
                mac_a = wsel(ACC_BITS'(y_q), int'(i_q));
                mac_b = wsel(ACC_BITS'(y_q), k);
                mac_c = (k == 0) ? '0 : c_q;
                mac_t = wsel(t_q, k);
                t_d   = put_acc(t_q, k, mac_lo);
                if (k == NUM_WRDS - 1) begin
                    wide = {1'b0, wsel(t_q, NUM_WRDS)} + {1'b0, mac_hi};
                    t_d  = put_acc(t_d, NUM_WRDS, wide[WRD_BITS-1:0]);
                    t_d  = put_acc(t_d, NUM_WRDS + 1, WRD_BITS'(wide[WRD_BITS]));
                end
            end
            ST_RED: begin
                if (j_q == '0) begin
                    mac_a = wsel(t_q, 0);
                    mac_b = inv_q;
                end else begin
                    // word k of t += m*P, written back one word lower (the shift)
                    k     = int'(j_q) - 1;
                    mac_a = m_q;
                    mac_b = wsel(ACC_BITS'(mod_q), k);
                    mac_c = (k == 0) ? '0 : c_q;
                    mac_t = wsel(t_q, k);
                    if (k > 0) t_d = put_acc(t_d, k - 1, mac_lo);
                    if (k == NUM_WRDS - 1) begin
                        wide = {1'b0, wsel(t_q, NUM_WRDS)} + {1'b0, mac_hi};
                        t_d  = put_acc(t_d, NUM_WRDS - 1, wide[WRD_BITS-1:0]);
                        t_d  = put_acc(t_d, NUM_WRDS,
                                       wsel(t_q, NUM_WRDS + 1) + WRD_BITS'(wide[WRD_BITS]));
                        t_d  = put_acc(t_d, NUM_WRDS + 1, '0);
                    end
                end
            end
            ST_SUB: begin
                k = int'(j_q);
                if (k < NUM_WRDS) begin
                    diff = {1'b0, wsel(t_q, k)} - {1'b0, wsel(ACC_BITS'(mod_q), k)}
                         - {{WRD_BITS{1'b0}}, (k == 0) ? 1'b0 : borrow_q};
                    d_d      = put_dat(d_q, k, diff[WRD_BITS-1:0]);
                    borrow_d = diff[WRD_BITS];
                end else begin
                    // t >= P unless the borrow ripples through the two top words
                    ge  = !(borrow_q && wsel(t_q, NUM_WRDS) == '0 && wsel(t_q, NUM_WRDS + 1) == '0);
                    y_d = ge ? d_q : t_q[DAT_BITS-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            mod_q    <= '0;
            y_q      <= '0;
            d_q      <= '0;
            t_q      <= '0;
            inv_q    <= '0;
            m_q      <= '0;
            c_q      <= '0;
            j_q      <= '0;
            i_q      <= '0;
            iter_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (i_val) begin
                    mod_q  <= i_modulus;
                    inv_q  <= i_mont_inv;
                    y_q    <= i_x;
                    iter_q <= i_iter;
                end
                ST_LOAD: begin
                    t_q <= '0;
                    j_q <= '0;
                    i_q <= '0;
                end
                ST_MULT: begin
                    t_q <= t_d;
                    c_q <= mac_hi;
                    j_q <= (int'(j_q) == NUM_WRDS - 1) ? '0 : j_q + 1'b1;
                end
                ST_RED: begin
                    t_q <= t_d;
                    if (j_q == '0) m_q <= mac_lo;
                    else           c_q <= mac_hi;
                    if (int'(j_q) == NUM_WRDS) begin
                        j_q <= '0;
                        i_q <= (int'(i_q) == NUM_WRDS - 1) ? '0 : i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                ST_SUB: begin
                    d_q      <= d_d;
                    borrow_q <= borrow_d;
                    if (int'(j_q) == NUM_WRDS) begin
                        y_q    <= y_d;
                        t_q    <= '0;
                        iter_q <= iter_q - 1'b1;
                        j_q    <= '0;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_y = y_q;

endmodule

// File: tb/tb_redun_mont_sq_iter.sv
// Bench for redun_mont_sq_iter at 8-bit words x 2: directed and random jobs against a modular-arithmetic model.
module tb_redun_mont_sq_iter;
    import redun_mont_sq_pkg::*;

    localparam int WB  = 8;
    localparam int NW  = 2;
    localparam int IW  = 8;
    localparam int LSQ = l_sq(NW);

    logic          i_clk;
    logic          i_rst;
    logic [15:0]   i_modulus;
    logic [7:0]    i_mont_inv;
    logic [15:0]   i_x;
    logic [IW-1:0] i_iter;
    logic          i_val;
    logic          o_rdy;
    logic [15:0]   o_y;
    logic          o_val;
    logic          i_rdy;
    logic          o_busy;
`ifdef REDUN_MONT_SQ_ABORT_EN
    logic          i_abort;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    redun_mont_sq_iter #(.WRD_BITS(WB), .NUM_WRDS(NW), .ITER_W(IW)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
`ifdef REDUN_MONT_SQ_ABORT_EN
        .i_abort    (i_abort),
`endif
        .i_modulus  (i_modulus),
        .i_mont_inv (i_mont_inv),
        .i_x        (i_x),
        .i_iter     (i_iter),
        .i_val      (i_val),
        .o_rdy      (o_rdy),
        .o_y        (o_y),
        .o_val      (o_val),
        .i_rdy      (i_rdy),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [7:0] calc_inv(input logic [15:0] p);
        logic [7:0] r;
        r = '0;
        for (int v = 0; v < 256; v++)
            if (((longint'(p) * v) & 255) == 255) r = 8'(v);
        return r;
    endfunction

    // y <- y*y*R^-1 mod P with R = 2^16, straight from the definition
    function automatic logic [15:0] model(input logic [15:0] p, input logic [15:0] x, input int t);
        longint pp, y, ri;
        pp = longint'(p);
        ri = 0;
        for (longint r = 1; r < pp; r++)
            if ((r * 65536) % pp == 1) begin
                ri = r;
                break;
            end
        y = longint'(x);
        for (int n = 0; n < t; n++) y = (((y * y) % pp) * ri) % pp;
        return 16'(y);
    endfunction

    task automatic launch(input logic [15:0] p, input logic [15:0] x, input int t);
        i_modulus  = p;
        i_mont_inv = calc_inv(p);
        i_x        = x;
        i_iter     = IW'(t);
        i_val      = 1'b1;
        check("rdy before accept", 32'(o_rdy), 32'd1);
        tick();
        i_val = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int t, input logic [15:0] exp, input int hold,
                              input bit dup);
        int  lat, cyc;
        bit  seen;
        lat  = 2 + t * LSQ;
        cyc  = 1;
        seen = o_val;
        check({tag, " busy"}, 32'(o_busy), 32'd1);
        while (!seen && cyc < lat + 20) begin
            if (dup && cyc == 3) begin
                i_val  = 1'b1;
                i_x    = 16'h5555;
                i_iter = IW'(7);
            end
            tick();
            i_val = 1'b0;
            cyc++;
            seen = o_val;
        end
        check({tag, " o_val"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " o_y"}, 32'(o_y), 32'(exp));
        repeat (hold) tick();
        check({tag, " held o_y"}, 32'(o_y), 32'(exp));
        check({tag, " held o_val"}, 32'(o_val), 32'd1);
        i_rdy = 1'b1;
        tick();
        i_rdy = 1'b0;
        check({tag, " idle rdy"}, 32'(o_rdy), 32'd1);
        check({tag, " idle val"}, 32'(o_val), 32'd0);
    endtask

    task automatic run_job(input string tag, input logic [15:0] p, input logic [15:0] x, input int t,
                           input int hold, input bit dup);
        logic [15:0] exp;
        exp = model(p, x, t);
        launch(p, x, t);
        finish_job(tag, t, exp, hold, dup);
    endtask

    task automatic expect_quiet(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (60) begin
            tick();
            if (o_val) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [15:0] p, x;
        int          t;
        i_rst      = 1'b1;
        i_val      = 1'b0;
        i_rdy      = 1'b0;
        i_modulus  = '0;
        i_mont_inv = '0;
        i_x        = '0;
        i_iter     = '0;
`ifdef REDUN_MONT_SQ_ABORT_EN
        i_abort    = 1'b0;
`endif
        repeat (2) tick();
        check("reset o_rdy", 32'(o_rdy), 32'd1);
        check("reset o_val", 32'(o_val), 32'd0);
        check("reset o_busy", 32'(o_busy), 32'd0);
        check("reset o_y", 32'(o_y), 32'd0);
        i_rst = 1'b0;
        tick();

        run_job("fixed point", 16'hFFF1, 16'h000F, 5, 0, 1'b0);
        run_job("x1e t3", 16'hFFF1, 16'h001E, 3, 0, 1'b0);
        run_job("t0", 16'hFFF1, 16'h1234, 0, 0, 1'b0);
        run_job("zero", 16'hFFF1, 16'h0000, 4, 2, 1'b0);
        run_job("hold dup", 16'hFFF1, 16'h001E, 1, 10, 1'b1);

        launch(16'hFFF1, 16'h001E, 3);
        repeat (19) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst o_rdy", 32'(o_rdy), 32'd1);
        check("midrst o_busy", 32'(o_busy), 32'd0);
        check("midrst o_y", 32'(o_y), 32'd0);
        expect_quiet("midrst no o_val");
        run_job("after rst", 16'hFFF1, 16'h001E, 3, 0, 1'b0);

`ifdef REDUN_MONT_SQ_ABORT_EN
        launch(16'hFFF1, 16'h001E, 3);
        repeat (14) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort o_rdy", 32'(o_rdy), 32'd1);
        check("abort o_val", 32'(o_val), 32'd0);
        run_job("after abort", 16'hFFF1, 16'h000F, 2, 0, 1'b0);
        i_abort = 1'b1;
        launch(16'hFFF1, 16'h001E, 3);
        i_abort = 1'b0;
        finish_job("idle abort", 3, 16'h0F00, 0, 1'b0);
        expect_quiet("abort quiet");
`endif

        for (int n = 0; n < 20; n++) begin
            p = 16'($urandom_range(3, 65535)) | 16'h0001;
            x = 16'($urandom % p);
            t = int'($urandom_range(0, 4));
            run_job("random", p, x, t, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
